pipe_ctrl_chain: RTL and testbench
==================================

PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of control-latch stages after decode (EX, MEM, WB for default), legal range 1..8.
REQ-002 SHALL have parameter CW, default 16, width of the per-instruction control bundle.
REQ-003 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  decode stage presents a real instruction (0 = bubble/flushed opcode).
REQ-008 in_ctrl  input  CW  decoded control bundle.
REQ-009 in_halt  input  1  instruction is HLT.
REQ-010 in_wwd  input  1  instruction is WWD.
REQ-011 stage_we  input  STAGES  per-stage write enable; bit k = 0 holds stage k.
REQ-012 stage_flush  input  STAGES  per-stage flush; bit k = 1 loads a bubble into stage k.
REQ-013 ctrl_out  output  STAGES*CW  stage k bundle at bits [k*CW +: CW].
REQ-014 valid_out  output  STAGES  stage k holds a real instruction.
REQ-015 retire  output  1  one-cycle pulse, an instruction retired from the last stage.
REQ-016 wwd_pulse  output  1  one-cycle pulse, the retiring instruction is WWD.
REQ-017 num_inst  output  CNT_W  count of retired instructions.
REQ-018 is_halted  output  1  sticky, a HLT has retired.

Function
REQ-019 Stage 0 SHALL load {in_valid, in_ctrl, in_halt, in_wwd} on a clock edge when stage_we[0]=1.
REQ-020 Stage k>0 SHALL load the contents of stage k-1 on a clock edge when stage_we[k]=1 and stage_we[k-1]=1.
REQ-021 Stage k>0 SHALL load a bubble when stage_we[k]=1 and stage_we[k-1]=0, so that a held upstream entry is never duplicated downstream.
REQ-022 A bubble SHALL be: valid=0, ctrl=0, halt=0, wwd=0.
REQ-023 stage_flush[k]=1 SHALL load a bubble into stage k regardless of stage_we[k]. Flush has priority over hold and over load.
REQ-024 stage_we[k]=0 with stage_flush[k]=0 SHALL leave every field of stage k unchanged, including the halt and wwd bits.
REQ-025 Each stage SHALL have one-cycle latency; an uninterrupted entry SHALL appear in the last stage STAGES cycles after capture.
REQ-026 An entry in the last stage SHALL retire exactly once, in the first cycle it is valid there.
REQ-027 A per-entry "counted" flag SHALL be cleared whenever the last stage loads or is flushed, and set after the entry retires.
REQ-028 retire SHALL be combinational: valid_out[STAGES-1] & ~counted.
REQ-029 wwd_pulse SHALL equal retire & last-stage wwd.
REQ-030 num_inst SHALL increment by 1 on the clock edge at which retire=1.
REQ-031 num_inst SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 is_halted SHALL be set on the edge following a retire whose halt bit is 1, and SHALL be cleared only by reset.
REQ-033 While is_halted=1, stage 0 SHALL capture bubbles and ignore in_valid. Entries already in flight SHALL still drain and retire.
REQ-034 A simultaneous flush of the last stage and a pending retire SHALL still count the retire, because retire is evaluated before the edge.

Reset
REQ-035 On reset assertion, all stages SHALL hold bubbles immediately.
REQ-036 On reset assertion, counted=1, num_inst=0, is_halted=0, retire=0, wwd_pulse=0 immediately.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight entries without counting them.
REQ-038 The first edge after reset deassertion SHALL behave as normal operation.

Verification
REQ-039 Stream: STAGES=3, all we=1, 5 valid entries ctrl=1..5 -> retire pulses on cycles 3..7, ctrl_out[2] = 1..5 in order, num_inst=5.
REQ-040 Stall: stage_we=3'b011 for 2 cycles with an entry in stage 1 -> stage 2 holds its value, no extra retire, num_inst unchanged; then stage_we=3'b100 for 1 cycle -> stage 2 receives a bubble, stage 1 is unchanged, the held entry is not duplicated.
REQ-041 Flush: stage_flush=3'b001 with in_valid=1 -> that entry never retires, and num_inst is short by 1 versus the unflushed run.
REQ-042 Halt: HLT followed by 3 valid entries -> is_halted=1 one cycle after the HLT retires; entries issued before the HLT retire; entries presented after is_halted=1 are ignored.
REQ-043 WWD/saturation: CNT_W=2, 5 valid entries with a WWD as entry 2 -> wwd_pulse only on the retire of entry 2, num_inst sticks at 3.
REQ-044 Async reset: assert reset between edges with 3 entries in flight -> valid_out=0 and num_inst=0 before the next edge, and no retire is seen after deassertion until a new entry arrives.

Source files
------------

// File: rtl/pipe_ctrl_chain.sv
// Control-bundle latch chain behind decode: per-stage hold/flush, retire detection,
// WWD pulse, saturating retired-instruction counter and sticky halt.
module pipe_ctrl_chain #(
  parameter int STAGES = 3,
  parameter int CW     = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_ctrl,
  input  logic                 in_halt,
  input  logic                 in_wwd,
  input  logic [STAGES-1:0]    stage_we,
  input  logic [STAGES-1:0]    stage_flush,
  output logic [STAGES*CW-1:0] ctrl_out,
  output logic [STAGES-1:0]    valid_out,
  output logic                 retire,
  output logic                 wwd_pulse,
  output logic [CNT_W-1:0]     num_inst,
  output logic                 is_halted
);

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] ctrl;
    logic          halt;
    logic          wwd;
  } entry_t;

  localparam int LAST = STAGES - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t             stage_q [STAGES];
  entry_t             in_entry;
  logic               counted_reg;
  logic               is_halted_reg;
  logic [CNT_W-1:0]   num_inst_reg;

  // Once halted, decode is ignored and only bubbles enter the chain.
  always_comb begin
    in_entry = '0;
    if (!is_halted_reg) begin
      in_entry.valid = in_valid;
      in_entry.ctrl  = in_ctrl;
      in_entry.halt  = in_halt;
      in_entry.wwd   = in_wwd;
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    entry_t src;
    entry_t stage_reg;

    if (gi == 0) begin : g_head
      assign src = in_entry;
    end else begin : g_tail
      // A held upstream stage feeds a bubble so its entry is not duplicated.
      assign src = stage_we[gi-1] ? stage_q[gi-1] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_reg <= '0;
      end else if (stage_flush[gi]) begin
        stage_reg <= '0;
      end else if (stage_we[gi]) begin
        stage_reg <= src;
      end
    end

    assign stage_q[gi]            = stage_reg;
    assign ctrl_out[gi*CW +: CW]  = stage_reg.ctrl;
    assign valid_out[gi]          = stage_reg.valid;
  end

  // counted marks a last-stage entry that has already retired while being held.
  assign retire    = stage_q[LAST].valid & ~counted_reg;
  assign wwd_pulse = retire & stage_q[LAST].wwd;
  assign num_inst  = num_inst_reg;
  assign is_halted = is_halted_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counted_reg   <= 1'b1;
      num_inst_reg  <= '0;
      is_halted_reg <= 1'b0;
    end else begin
      if (stage_flush[LAST] || stage_we[LAST]) begin
        counted_reg <= 1'b0;
      end else if (retire) begin
        counted_reg <= 1'b1;
      end
      if (retire && (num_inst_reg != CNT_MAX)) begin
        num_inst_reg <= num_inst_reg + CNT_W'(1);
      end
      if (retire && stage_q[LAST].halt) begin
        is_halted_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Table-driven bench for pipe_ctrl_chain (STAGES=3), with a CNT_W=2 twin for saturation.
module tb_pipe_ctrl_chain;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_ctrl;
  logic        in_halt;
  logic        in_wwd;
  logic [2:0]  stage_we;
  logic [2:0]  stage_flush;
  logic [47:0] ctrl_out;
  logic [2:0]  valid_out;
  logic        retire;
  logic        wwd_pulse;
  logic [15:0] num_inst;
  logic        is_halted;

  logic [47:0] ctrl_out_s;
  logic [2:0]  valid_out_s;
  logic        retire_s;
  logic        wwd_pulse_s;
  logic [1:0]  num_inst_s;
  logic        is_halted_s;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_chain #(.STAGES(3), .CW(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_halt(in_halt), .in_wwd(in_wwd), .stage_we(stage_we), .stage_flush(stage_flush),
    .ctrl_out(ctrl_out), .valid_out(valid_out), .retire(retire), .wwd_pulse(wwd_pulse),
    .num_inst(num_inst), .is_halted(is_halted)
  );

  pipe_ctrl_chain #(.STAGES(3), .CW(16), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_halt(in_halt), .in_wwd(in_wwd), .stage_we(stage_we), .stage_flush(stage_flush),
    .ctrl_out(ctrl_out_s), .valid_out(valid_out_s), .retire(retire_s), .wwd_pulse(wwd_pulse_s),
    .num_inst(num_inst_s), .is_halted(is_halted_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [2:0]  we;
    logic [2:0]  fl;
    logic        v;
    logic [15:0] c;
    logic        h;
    logic        w;
    logic [2:0]  evo;
    logic [15:0] ec1;
    logic [15:0] ec2;
    logic        er;
    logic        ew;
    int          en;
    logic        eh;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input logic [2:0] we, input logic [2:0] fl,
                     input logic v, input logic [15:0] c, input logic h, input logic w,
                     input logic [2:0] evo, input logic [15:0] ec1, input logic [15:0] ec2,
                     input logic er, input logic ew, input int en, input logic eh);
    vec_t t;
    t.rst = rst; t.we = we; t.fl = fl; t.v = v; t.c = c; t.h = h; t.w = w;
    t.evo = evo; t.ec1 = ec1; t.ec2 = ec2; t.er = er; t.ew = ew; t.en = en; t.eh = eh;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] we, input logic [2:0] fl, input logic v,
                       input logic [15:0] c, input logic h, input logic w);
    stage_we = we; stage_flush = fl; in_valid = v; in_ctrl = c; in_halt = h; in_wwd = w;
  endtask

  // Drive, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [2:0] we, input logic [2:0] fl, input logic v,
                      input logic [15:0] c);
    drive(we, fl, v, c, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(3'b111, 3'b000, 1'b0, 16'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_num_inst", 32'(num_inst), 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    @(posedge clk);
    #4;
    reset = 1'b0;
  endtask

  initial begin
    int exp_sat;
    reset = 1'b0;
    drive(3'b111, 3'b000, 1'b0, 16'h0, 1'b0, 1'b0);

    // Stream of 5 with entry 2 being WWD (also drives the CNT_W=2 twin to saturation).
    add(1, 3'b111, 3'b000, 1'b1, 16'd1, 1'b0, 1'b0, 3'b001, 16'd0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd2, 1'b0, 1'b1, 3'b011, 16'd1, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd3, 1'b0, 1'b0, 3'b111, 16'd2, 16'd1, 1'b1, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd4, 1'b0, 1'b0, 3'b111, 16'd3, 16'd2, 1'b1, 1'b1, 1, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd5, 1'b0, 1'b0, 3'b111, 16'd4, 16'd3, 1'b1, 1'b0, 2, 1'b0);
    add(0, 3'b111, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b110, 16'd5, 16'd4, 1'b1, 1'b0, 3, 1'b0);
    add(0, 3'b111, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b100, 16'd0, 16'd5, 1'b1, 1'b0, 4, 1'b0);
    add(0, 3'b111, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b000, 16'd0, 16'd0, 1'b0, 1'b0, 5, 1'b0);
    // Stall of the last stage, then upstream hold feeding a bubble.
    add(1, 3'b111, 3'b000, 1'b1, 16'd7, 1'b0, 1'b0, 3'b001, 16'd0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd8, 1'b0, 1'b0, 3'b011, 16'd7, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd9, 1'b0, 1'b0, 3'b111, 16'd8, 16'd7, 1'b1, 1'b0, 0, 1'b0);
    add(0, 3'b011, 3'b000, 1'b1, 16'd10, 1'b0, 1'b0, 3'b111, 16'd9, 16'd7, 1'b0, 1'b0, 1, 1'b0);
    add(0, 3'b011, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b110, 16'd10, 16'd7, 1'b0, 1'b0, 1, 1'b0);
    add(0, 3'b100, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b010, 16'd10, 16'd0, 1'b0, 1'b0, 1, 1'b0);
    add(0, 3'b111, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b100, 16'd0, 16'd10, 1'b1, 1'b0, 1, 1'b0);
    add(0, 3'b111, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b000, 16'd0, 16'd0, 1'b0, 1'b0, 2, 1'b0);
    // Flush of stage 0 while entry 3 is presented.
    add(1, 3'b111, 3'b000, 1'b1, 16'd1, 1'b0, 1'b0, 3'b001, 16'd0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd2, 1'b0, 1'b0, 3'b011, 16'd1, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b001, 1'b1, 16'd3, 1'b0, 1'b0, 3'b110, 16'd2, 16'd1, 1'b1, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd4, 1'b0, 1'b0, 3'b101, 16'd0, 16'd2, 1'b1, 1'b0, 1, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd5, 1'b0, 1'b0, 3'b011, 16'd4, 16'd0, 1'b0, 1'b0, 2, 1'b0);
    add(0, 3'b111, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b110, 16'd5, 16'd4, 1'b1, 1'b0, 2, 1'b0);
    add(0, 3'b111, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b100, 16'd0, 16'd5, 1'b1, 1'b0, 3, 1'b0);
    add(0, 3'b111, 3'b000, 1'b0, 16'd0, 1'b0, 1'b0, 3'b000, 16'd0, 16'd0, 1'b0, 1'b0, 4, 1'b0);
    // HLT followed by valid entries; entry 5 arrives after is_halted and is dropped.
    add(1, 3'b111, 3'b000, 1'b1, 16'd17, 1'b1, 1'b0, 3'b001, 16'd0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd2, 1'b0, 1'b0, 3'b011, 16'd17, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd3, 1'b0, 1'b0, 3'b111, 16'd2, 16'd17, 1'b1, 1'b0, 0, 1'b0);
    add(0, 3'b111, 3'b000, 1'b1, 16'd4, 1'b0, 1'b0, 3'b111, 16'd3, 16'd2, 1'b1, 1'b0, 1, 1'b1);
    add(0, 3'b111, 3'b000, 1'b1, 16'd5, 1'b0, 1'b0, 3'b110, 16'd4, 16'd3, 1'b1, 1'b0, 2, 1'b1);
    add(0, 3'b111, 3'b000, 1'b1, 16'd6, 1'b0, 1'b0, 3'b100, 16'd0, 16'd4, 1'b1, 1'b0, 3, 1'b1);
    add(0, 3'b111, 3'b000, 1'b1, 16'd7, 1'b0, 1'b0, 3'b000, 16'd0, 16'd0, 1'b0, 1'b0, 4, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].we, vecs[i].fl, vecs[i].v, vecs[i].c, vecs[i].h, vecs[i].w);
      @(posedge clk);
      #1;
      exp_sat = (vecs[i].en > 3) ? 3 : vecs[i].en;
      chk($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(vecs[i].evo));
      chk($sformatf("row%0d ctrl1", i), 32'(ctrl_out[16 +: 16]), 32'(vecs[i].ec1));
      chk($sformatf("row%0d ctrl2", i), 32'(ctrl_out[32 +: 16]), 32'(vecs[i].ec2));
      chk($sformatf("row%0d retire", i), 32'(retire), 32'(vecs[i].er));
      chk($sformatf("row%0d wwd_pulse", i), 32'(wwd_pulse), 32'(vecs[i].ew));
      chk($sformatf("row%0d num_inst", i), 32'(num_inst), 32'(vecs[i].en));
      chk($sformatf("row%0d num_inst_sat", i), 32'(num_inst_s), 32'(exp_sat));
      chk($sformatf("row%0d is_halted", i), 32'(is_halted), 32'(vecs[i].eh));
      $display("row %0d: vo=%b c1=%0d c2=%0d ret=%b wwd=%b num=%0d sat=%0d halt=%b",
               i, valid_out, ctrl_out[16 +: 16], ctrl_out[32 +: 16], retire, wwd_pulse,
               num_inst, num_inst_s, is_halted);
    end

    // Flush of the last stage in the same cycle its entry retires still counts it.
    do_reset();
    step(3'b111, 3'b000, 1'b1, 16'h40);
    step(3'b111, 3'b000, 1'b0, 16'h0);
    step(3'b111, 3'b000, 1'b0, 16'h0);
    chk("flushlast_retire_pending", 32'(retire), 32'h1);
    step(3'b011, 3'b100, 1'b0, 16'h0);
    chk("flushlast_valid", 32'(valid_out), 32'h0);
    chk("flushlast_num", 32'(num_inst), 32'h1);
    $display("flush-last: vo=%b num=%0d", valid_out, num_inst);

    // Asynchronous reset between edges with three entries in flight.
    do_reset();
    step(3'b111, 3'b000, 1'b1, 16'h21);
    step(3'b111, 3'b000, 1'b0, 16'h0);
    step(3'b111, 3'b000, 1'b0, 16'h0);
    step(3'b111, 3'b000, 1'b1, 16'h22);
    chk("async_pre_num", 32'(num_inst), 32'h1);
    step(3'b111, 3'b000, 1'b1, 16'h23);
    step(3'b111, 3'b000, 1'b1, 16'h24);
    chk("async_pre_valid", 32'(valid_out), 32'h7);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(valid_out), 32'h0);
    chk("async_num", 32'(num_inst), 32'h0);
    chk("async_retire", 32'(retire), 32'h0);
    $display("async reset: vo=%b num=%0d ret=%b", valid_out, num_inst, retire);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(3'b111, 3'b000, 1'b0, 16'h0);
      chk($sformatf("post_rst_idle%0d retire", k), 32'(retire), 32'h0);
    end
    chk("post_rst_idle_num", 32'(num_inst), 32'h0);
    step(3'b111, 3'b000, 1'b1, 16'h30);
    step(3'b111, 3'b000, 1'b0, 16'h0);
    step(3'b111, 3'b000, 1'b0, 16'h0);
    chk("post_rst_new_retire", 32'(retire), 32'h1);
    chk("post_rst_new_ctrl2", 32'(ctrl_out[32 +: 16]), 32'h30);
    step(3'b111, 3'b000, 1'b0, 16'h0);
    chk("post_rst_new_num", 32'(num_inst), 32'h1);
    $display("post-reset entry: num=%0d", num_inst);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
